spi_slave_cmd_ctrl: RTL and testbench

// - Command sequencer between the SPI word deserialiser and spi_slave_axi_plug, on the axi_aclk domain.
// - Decodes the first 32-bit word of each chip-select frame as a command and loads the plug's address.
// - Then either forwards write data to the plug or triggers the plug's read after a programmable dummy phase.
// - Holds the dummy-word count register and flags unknown opcodes.

---
 rtl/spi_slave_cmd_ctrl.sv | 136 +++++++++++++
 tb/tb_spi_slave_cmd_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_cmd_ctrl.sv
// Command sequencer between the SPI word deserialiser and the AXI plug.
// Decodes the frame command, loads the plug address, then forwards write data or triggers a read.
module spi_slave_cmd_ctrl #(
   parameter logic [7:0] OP_WR_MEM   = 8'h02,
   parameter logic [7:0] OP_RD_MEM   = 8'h0B,
   parameter logic [7:0] OP_WR_DUMMY = 8'h71,
   parameter logic [7:0] DUMMY_RST   = 8'd1
) (
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   input  logic        cs,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] rxtx_addr,
   output logic        rxtx_addr_valid,
   output logic        start_tx,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [7:0]  dummy_words,
   output logic        cmd_err
);

   // state | meaning
   // IDLE  | chip deselected or first cycle of a frame
   // CMD   | waiting for the command word
   // ADDR  | waiting for the address word
   // WDATA | forwarding write data to the plug
   // DUMMY | counting dummy words before a read
   // DROP  | discarding words until the frame ends
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, DROP} state_t;

   state_t     state, state_nxt;
   logic       is_rd;
   logic [7:0] cnt;

   logic       addr_load, start_nxt, err_nxt, dummy_load, cnt_load, cnt_dec, kind_load;
   logic       word;
   logic [7:0] opcode;

   assign rx_data = in_data;
   assign opcode  = in_data[31:24];
   assign word    = in_valid & in_ready;

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      rx_valid   = 1'b0;
      addr_load  = 1'b0;
      start_nxt  = 1'b0;
      err_nxt    = 1'b0;
      dummy_load = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      kind_load  = 1'b0;
      if (cs) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = CMD;
            CMD: begin
               in_ready = 1'b1;
               if (word) begin
                  if (opcode == OP_WR_MEM || opcode == OP_RD_MEM) begin
                     kind_load = 1'b1;
                     state_nxt = ADDR;
                  end else if (opcode == OP_WR_DUMMY) begin
                     dummy_load = 1'b1;
                     state_nxt  = DROP;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = DROP;
                  end
               end
            end
            ADDR: begin
               in_ready = 1'b1;
               if (word) begin
                  addr_load = 1'b1;
                  if (!is_rd) begin
                     state_nxt = WDATA;
                  end else if (dummy_words == 8'd0) begin
                     start_nxt = 1'b1;
                     state_nxt = DROP;
                  end else begin
                     cnt_load  = 1'b1;
                     state_nxt = DUMMY;
                  end
               end
            end
            WDATA: begin
               in_ready = rx_ready;
               rx_valid = in_valid;
            end
            DUMMY: begin
               in_ready = 1'b1;
               if (word) begin
                  cnt_dec = 1'b1;
                  if (cnt == 8'd1) begin
                     start_nxt = 1'b1;
                     state_nxt = DROP;
                  end
               end
            end
            DROP:    in_ready = 1'b1;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state           <= IDLE;
         rxtx_addr       <= 32'd0;
         rxtx_addr_valid <= 1'b0;
         start_tx        <= 1'b0;
         cmd_err         <= 1'b0;
         dummy_words     <= DUMMY_RST;
         cnt             <= 8'd0;
         is_rd           <= 1'b0;
      end else begin
         state           <= state_nxt;
         rxtx_addr_valid <= addr_load;
         start_tx        <= start_nxt;
         cmd_err         <= err_nxt;
         if (addr_load)  rxtx_addr   <= in_data;
         if (dummy_load) dummy_words <= in_data[7:0];
         if (kind_load)  is_rd       <= (opcode == OP_RD_MEM);
         // counter only ever starts from a non-zero count, so it stops at 0
         if (cnt_load)      cnt <= dummy_words;
         else if (cnt_dec)  cnt <= cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Bench for spi_slave_cmd_ctrl: a per-cycle table for a write frame, directed corner cases,
// and random frames checked against a word-index model of the command protocol.
module tb_spi_slave_cmd_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs = 1'b1;
   logic        in_valid = 1'b0;
   logic        rx_ready = 1'b1;
   logic [31:0] in_data = 32'd0;
   logic        in_ready, rxtx_addr_valid, start_tx, rx_valid, cmd_err;
   logic [31:0] rxtx_addr, rx_data;
   logic [7:0]  dummy_words;

   always #5 clk = ~clk;

   spi_slave_cmd_ctrl dut (
      .axi_aclk(clk), .axi_aresetn(rst_n), .cs(cs), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .rxtx_addr(rxtx_addr), .rxtx_addr_valid(rxtx_addr_valid),
      .start_tx(start_tx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .dummy_words(dummy_words), .cmd_err(cmd_err)
   );

   int n_cmp = 0, n_bad = 0;

   // model: frame cycle c, accepted word index k, opcode of the frame
   int          c, k, cyc;
   logic [7:0]  op, m_dummy, nxt_dummy;
   logic [31:0] m_addr, nxt_addr;
   logic        e_av, e_st, e_err, n_av, n_st, n_err, n_dload;
   int          av_cnt, st_cnt, err_cnt, both_cnt, av_cyc, st_cyc;
   logic [31:0] fq[$];

   typedef struct {
      logic cs, v; logic [31:0] d; logic rr;
      logic ir, rxv, av, st; logic [31:0] addr;
   } vec_t;
   vec_t tbl[8];

   int          len, sel, ncs;
   logic [31:0] w0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      c = 0; k = 0; op = 8'h00; m_dummy = 8'd1; m_addr = 32'd0;
      e_av = 0; e_st = 0; e_err = 0; n_av = 0; n_st = 0; n_err = 0; n_dload = 0;
      nxt_dummy = 8'd0; nxt_addr = 32'd0;
   endtask

   task automatic drive(input logic s, input logic v, input logic [31:0] d, input logic rr);
      logic ok, wr_phase, e_ir, e_rxv;
      cs = s; in_valid = v; in_data = d; rx_ready = rr;
      #4;
      ok       = !s && (c >= 1);
      wr_phase = (k >= 2) && (op == 8'h02);
      e_ir     = ok && (wr_phase ? rr : 1'b1);
      e_rxv    = ok && wr_phase && v;
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("rx_valid", 32'(rx_valid), 32'(e_rxv));
      if (e_rxv) chk("rx_data", rx_data, d);
      chk("addr_valid", 32'(rxtx_addr_valid), 32'(e_av));
      chk("start_tx", 32'(start_tx), 32'(e_st));
      chk("cmd_err", 32'(cmd_err), 32'(e_err));
      chk("rxtx_addr", rxtx_addr, m_addr);
      chk("dummy_words", 32'(dummy_words), 32'(m_dummy));
      if (rxtx_addr_valid) begin av_cnt++; av_cyc = cyc; end
      if (start_tx) begin st_cnt++; st_cyc = cyc; end
      if (cmd_err) err_cnt++;
      if (rxtx_addr_valid && start_tx) both_cnt++;
      if (e_ir && v) begin
         if (k == 0) begin
            op = d[31:24];
            if (op == 8'h71) begin n_dload = 1; nxt_dummy = d[7:0]; end
            else if (op != 8'h02 && op != 8'h0B) n_err = 1;
         end else if (k == 1 && (op == 8'h02 || op == 8'h0B)) begin
            n_av = 1; nxt_addr = d;
            if (op == 8'h0B && m_dummy == 8'd0) n_st = 1;
         end else if (op == 8'h0B && m_dummy != 8'd0 && k == 1 + int'(m_dummy)) begin
            n_st = 1;
         end
         k++;
      end
      if (s) begin c = 0; k = 0; end
      else c++;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      e_av = n_av; e_st = n_st; e_err = n_err;
      if (n_av) m_addr = nxt_addr;
      if (n_dload) m_dummy = nxt_dummy;
      n_av = 0; n_st = 0; n_err = 0; n_dload = 0;
      cyc++;
   endtask

   task automatic step(input logic s, input logic v, input logic [31:0] d, input logic rr);
      drive(s, v, d, rr);
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cs = 1'b1; in_valid = 1'b0; rx_ready = 1'b1;
      model_reset();
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_addr_valid", 32'(rxtx_addr_valid), 32'd0);
      chk("rst_start_tx", 32'(start_tx), 32'd0);
      chk("rst_cmd_err", 32'(cmd_err), 32'd0);
      chk("rst_rxtx_addr", rxtx_addr, 32'd0);
      chk("rst_dummy_words", 32'(dummy_words), 32'd1);
      rst_n = 1'b1;
   endtask

   task automatic clear_obs();
      av_cnt = 0; st_cnt = 0; err_cnt = 0; both_cnt = 0; av_cyc = 0; st_cyc = 0;
   endtask

   task automatic run_frame();
      clear_obs();
      step(1'b0, 1'b0, 32'd0, 1'b1);
      while (fq.size() > 0) step(1'b0, 1'b1, fq.pop_front(), 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h02000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 32'h02000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[3] = '{1'b0, 1'b1, 32'h1C000010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[4] = '{1'b0, 1'b1, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1C000010};
      tbl[5] = '{1'b0, 1'b1, 32'h11223344, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1C000010};
      tbl[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C000010};
      tbl[7] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C000010};
      cyc = 0;
      clear_obs();
      do_reset();

      // write frame, table driven
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].cs, tbl[i].v, tbl[i].d, tbl[i].rr);
         chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].ir));
         chk("tbl_rx_valid", 32'(rx_valid), 32'(tbl[i].rxv));
         if (tbl[i].rxv) chk("tbl_rx_data", rx_data, tbl[i].d);
         chk("tbl_addr_valid", 32'(rxtx_addr_valid), 32'(tbl[i].av));
         chk("tbl_start_tx", 32'(start_tx), 32'(tbl[i].st));
         chk("tbl_rxtx_addr", rxtx_addr, tbl[i].addr);
         tick();
      end

      // read with reset dummy count
      fq = '{32'h0B000000, 32'h1C000020, 32'hDEAD0001, 32'h12345678, 32'h9ABCDEF0};
      run_frame();
      chk("rd_av_cnt", av_cnt, 1);
      chk("rd_st_cnt", st_cnt, 1);
      chk("rd_st_gap", st_cyc - av_cyc, 1);

      // dummy count 0: start coincides with addr_valid
      fq = '{32'h71000000, 32'h5555AAAA};
      run_frame();
      chk("cfg0_dummy", 32'(dummy_words), 32'd0);
      fq = '{32'h0B000000, 32'h1C000040, 32'h1, 32'h2};
      run_frame();
      chk("rd0_both", both_cnt, 1);
      chk("rd0_st_cnt", st_cnt, 1);

      // 255 dummies
      fq = '{32'h710000FF};
      run_frame();
      chk("cfg255_dummy", 32'(dummy_words), 32'd255);
      fq = '{32'h0B000000, 32'h1C000080};
      for (int i = 0; i < 257; i++) fq.push_back(32'(i));
      run_frame();
      chk("rd255_st_cnt", st_cnt, 1);
      chk("rd255_gap", st_cyc - av_cyc, 255);

      // bad opcode, then a normal frame
      fq = '{32'h55000000, 32'h1C000000, 32'h0B000000};
      run_frame();
      chk("bad_err_cnt", err_cnt, 1);
      chk("bad_av_cnt", av_cnt, 0);
      fq = '{32'h02000000, 32'h1C0000C0, 32'h77};
      run_frame();
      chk("after_bad_av_cnt", av_cnt, 1);
      chk("after_bad_err_cnt", err_cnt, 0);

      // frame aborted in ADDR
      clear_obs();
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 32'h02000000, 1'b1);
      step(1'b1, 1'b1, 32'h1C000100, 1'b1);
      drive(1'b0, 1'b1, 32'h1C000100, 1'b1);
      chk("abort_addr_idle", 32'(in_ready), 32'd0);
      tick();
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      chk("abort_addr_av", av_cnt, 0);

      // frame aborted in DUMMY with one dummy left
      fq = '{32'h71000001};
      run_frame();
      clear_obs();
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 32'h0B000000, 1'b1);
      step(1'b0, 1'b1, 32'h1C000200, 1'b1);
      step(1'b1, 1'b1, 32'hD0D0D0D0, 1'b1);
      drive(1'b0, 1'b1, 32'hD0D0D0D0, 1'b1);
      chk("abort_dummy_idle", 32'(in_ready), 32'd0);
      tick();
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      chk("abort_dummy_st", st_cnt, 0);

      // backpressure in WDATA
      fq = '{32'h71000003};
      run_frame();
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 32'h02000000, 1'b1);
      step(1'b0, 1'b1, 32'h1C000300, 1'b1);
      step(1'b0, 1'b1, 32'h01010101, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 32'hBEEF0001, 1'b0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_rx_data", rx_data, 32'hBEEF0001);
         tick();
      end
      step(1'b0, 1'b1, 32'hBEEF0001, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b1);

      // async reset mid-WDATA while the addr_valid pulse is up
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b1, 32'h02000000, 1'b1);
      step(1'b0, 1'b1, 32'h1C000400, 1'b1);
      drive(1'b0, 1'b1, 32'hCAFE0000, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_rx_valid", 32'(rx_valid), 32'd0);
      chk("arst_addr_valid", 32'(rxtx_addr_valid), 32'd0);
      chk("arst_rxtx_addr", rxtx_addr, 32'd0);
      chk("arst_dummy_words", 32'(dummy_words), 32'd1);
      do_reset();

      // random frames
      for (int f = 0; f < 60; f++) begin
         len = $urandom_range(1, 14);
         sel = $urandom_range(0, 3);
         ncs = $urandom_range(1, 2);
         case (sel)
            0:       w0 = {8'h02, 24'($urandom)};
            1:       w0 = {8'h0B, 24'($urandom)};
            2:       w0 = {8'h71, 16'($urandom), 8'($urandom_range(0, 3))};
            default: w0 = $urandom;
         endcase
         for (int i = 0; i < len; i++)
            step(1'b0, 1'(($urandom % 4) != 0), (k == 0) ? w0 : $urandom, 1'(($urandom % 3) != 0));
         for (int i = 0; i < ncs; i++)
            step(1'b1, 1'($urandom % 2), $urandom, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
